// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- interrupt controller with per-source gateway FSMs and claim/complete
//
// Each source line is synchronized and then handled by a gateway FSM
// (IDLE -> PENDING -> CLAIMED -> IDLE). A claim grants the lowest-numbered
// source that is both PENDING and enabled. A completion returns the claimed
// source to IDLE. irq_out is a registered OR of the PENDING & enabled sources.
//
// Optional feature macro: IRQ_EDGE_DETECT_EN
//   defined   : sources with edge_mode=1 pend only on a synchronized rising edge.
//               An edge seen while CLAIMED is remembered (rearm), so that
//               completion goes straight back to PENDING.
//   undefined : every source is level-sensitive and edge_mode is ignored.
//
// Ports
//   clk          : sole clock, rising edge
//   nrst         : asynchronous active-low reset
//   irq_src      : asynchronous interrupt lines, bit i = source i+1
//   edge_mode    : per-source 1=edge / 0=level (edge build only)
//   enable_we    : write strobe for the enable mask
//   enable_wdata : new enable mask
//   enable_q     : current enable mask
//   pending_q    : per-source PENDING flags
//   claim_req    : single-cycle claim request
//   claim_valid  : claim response pulse, one cycle after claim_req
//   claim_id     : claimed source ID (0 = none), held until the next response
//   complete_req : single-cycle completion strobe
//   complete_id  : ID being completed
//   irq_out      : registered interrupt request to the hart
// -----------------------------------------------------------------------------
module irq_ctrl #(
   parameter  int NSRC        = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int IDW         = $clog2(NSRC + 1)
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [NSRC-1:0] irq_src,
   input  logic [NSRC-1:0] edge_mode,
   input  logic            enable_we,
   input  logic [NSRC-1:0] enable_wdata,
   output logic [NSRC-1:0] enable_q,
   output logic [NSRC-1:0] pending_q,
   input  logic            claim_req,
   output logic            claim_valid,
   output logic [IDW-1:0]  claim_id,
   input  logic            complete_req,
   input  logic [IDW-1:0]  complete_id,
   output logic            irq_out
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLAIMED = 2'd2
   } gw_state_e;

   // ---------------------------------------------------------------- synchronizer
   logic [NSRC-1:0] sync_q [SYNC_STAGES];
   logic [NSRC-1:0] sync_d [SYNC_STAGES];
   logic [NSRC-1:0] synced;

   always_comb begin
      sync_d[0] = irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- gateways
   gw_state_e       gw_state_q [NSRC];
   gw_state_e       gw_state_d [NSRC];
   logic [NSRC-1:0] set_pend;      // IDLE source asks to become PENDING
   logic [NSRC-1:0] rearm_now;     // completion should return to PENDING
   logic [NSRC-1:0] complete_hit;  // completion addressed to this source
   logic [NSRC-1:0] claimable;
   logic [NSRC-1:0] win_onehot;
   logic [IDW-1:0]  win_id;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign pending_q[gi]    = (gw_state_q[gi] == ST_PENDING);
      // IDs 0 and > NSRC never match any source, so they fall out naturally.
      assign complete_hit[gi] = complete_req && (complete_id == IDW'(gi + 1));
   end

   // Claim arbitration uses registered state and the registered mask only, so a
   // source completed or enabled in this same cycle cannot win.
   assign claimable  = pending_q & enable_q;
   assign win_onehot = claimable & (~claimable + NSRC'(1));

   always_comb begin
      win_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (claimable[i]) begin
            win_id = IDW'(i + 1);
         end
      end
   end

`ifdef IRQ_EDGE_DETECT_EN
   logic [NSRC-1:0] hist_q, hist_d;
   logic [NSRC-1:0] rearm_q, rearm_d;
   logic [NSRC-1:0] rise;

   assign hist_d    = synced;
   assign rise      = synced & ~hist_q;
   assign set_pend  = (edge_mode & rise) | (~edge_mode & synced);
   // An edge landing in the completion cycle itself also counts as a rearm.
   assign rearm_now = rearm_q | (edge_mode & rise);

   always_comb begin
      rearm_d = rearm_q;
      for (int i = 0; i < NSRC; i++) begin
         if (gw_state_q[i] != ST_CLAIMED || complete_hit[i]) begin
            rearm_d[i] = 1'b0;
         end else if (edge_mode[i] && rise[i]) begin
            rearm_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hist_q  <= '0;
         rearm_q <= '0;
      end else begin
         hist_q  <= hist_d;
         rearm_q <= rearm_d;
      end
   end
`else
   logic unused_edge_mode;
   assign unused_edge_mode = ^edge_mode;
   assign set_pend         = synced;
   assign rearm_now        = '0;
`endif

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         gw_state_d[i] = gw_state_q[i];
         case (gw_state_q[i])
            ST_IDLE: begin
               if (set_pend[i]) gw_state_d[i] = ST_PENDING;
            end
            ST_PENDING: begin
               // Level dropping here is deliberately ignored.
               if (claim_req && win_onehot[i]) gw_state_d[i] = ST_CLAIMED;
            end
            ST_CLAIMED: begin
               if (complete_hit[i]) gw_state_d[i] = rearm_now[i] ? ST_PENDING : ST_IDLE;
            end
            default: gw_state_d[i] = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   logic [NSRC-1:0] enable_d;
   logic            claim_valid_q, claim_valid_d;
   logic [IDW-1:0]  claim_id_q, claim_id_d;
   logic            irq_out_q, irq_out_d;

   always_comb begin
      enable_d      = enable_we ? enable_wdata : enable_q;
      claim_valid_d = claim_req;
      claim_id_d    = claim_req ? win_id : claim_id_q;
      irq_out_d     = |claimable;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NSRC; i++) begin
            gw_state_q[i] <= ST_IDLE;
         end
         enable_q      <= '0;
         claim_valid_q <= 1'b0;
         claim_id_q    <= '0;
         irq_out_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            gw_state_q[i] <= gw_state_d[i];
         end
         enable_q      <= enable_d;
         claim_valid_q <= claim_valid_d;
         claim_id_q    <= claim_id_d;
         irq_out_q     <= irq_out_d;
      end
   end

   assign claim_valid = claim_valid_q;
   assign claim_id    = claim_id_q;
   assign irq_out     = irq_out_q;

endmodule
